// File: rtl/systolic_array.sv
// Output-stationary DIM x DIM signed MAC grid computing C = A*B in place from skewed A/B operand streams.
// Latency: operands advance one PE per en step, result complete after 3*DIM-2 steps; Cout is a combinational read.
// Backpressure: none; deasserting en pauses the whole grid, and a WrEn row write overrides that row's accumulation.
module systolic_array #(
  parameter int DIM     = 8,
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       WrEn,
  input  logic [$clog2(DIM)-1:0]     Crow,
  input  logic [DIM*BITS_AB-1:0]     A,
  input  logic [DIM*BITS_AB-1:0]     B,
  input  logic [DIM*BITS_C-1:0]      Cin,
  output logic [DIM*BITS_C-1:0]      Cout
);

  // Full-precision product width, and a width wide enough to sign-extend
  // the product before it is cut down to the accumulator width.
  localparam int PW = 2 * BITS_AB;
  localparam int XW = (BITS_C > PW) ? BITS_C : PW;

  logic signed [BITS_AB-1:0] a_reg  [DIM][DIM];
  logic signed [BITS_AB-1:0] b_reg  [DIM][DIM];
  logic signed [BITS_C-1:0]  c_reg  [DIM][DIM];

  logic signed [BITS_AB-1:0] a_in   [DIM][DIM];
  logic signed [BITS_AB-1:0] b_in   [DIM][DIM];
  logic signed [PW-1:0]      prod   [DIM][DIM];
  logic signed [XW-1:0]      prod_x [DIM][DIM];
  logic signed [BITS_C-1:0]  c_nxt  [DIM][DIM];
  logic        [DIM-1:0]     row_wr;

  // Operand routing: A enters at column 0 and moves right, B enters at row 0 and moves down.
  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      a_in[i][0] = A[i*BITS_AB +: BITS_AB];
      for (int j = 1; j < DIM; j++) begin
        a_in[i][j] = a_reg[i][j-1];
      end
    end
    for (int j = 0; j < DIM; j++) begin
      b_in[0][j] = B[j*BITS_AB +: BITS_AB];
      for (int i = 1; i < DIM; i++) begin
        b_in[i][j] = b_reg[i-1][j];
      end
    end
  end

  // Per-PE signed multiply; the product is sign-extended, then wrapped into the accumulator width.
  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        prod[i][j]   = a_in[i][j] * b_in[i][j];
        prod_x[i][j] = XW'(prod[i][j]);
        c_nxt[i][j]  = c_reg[i][j] + prod_x[i][j][BITS_C-1:0];
      end
    end
  end

  // Row write decode; a Crow beyond the last row matches nothing, so the write is dropped.
  always_comb begin
    row_wr = '0;
    for (int i = 0; i < DIM; i++) begin
      row_wr[i] = WrEn && (int'(Crow) == i);
    end
  end

  // Read mux: selected row of accumulators, zero when Crow addresses no row.
  always_comb begin
    Cout = '0;
    for (int i = 0; i < DIM; i++) begin
      if (int'(Crow) == i) begin
        for (int j = 0; j < DIM; j++) begin
          Cout[j*BITS_C +: BITS_C] = c_reg[i][j];
        end
      end
    end
  end

  // PE state: operands shift and accumulate on en; a row write replaces that row's sums but not its operand shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DIM; i++) begin
        for (int j = 0; j < DIM; j++) begin
          a_reg[i][j] <= '0;
          b_reg[i][j] <= '0;
          c_reg[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < DIM; i++) begin
        for (int j = 0; j < DIM; j++) begin
          if (en) begin
            a_reg[i][j] <= a_in[i][j];
            b_reg[i][j] <= b_in[i][j];
          end
          if (row_wr[i]) begin
            c_reg[i][j] <= Cin[j*BITS_C +: BITS_C];
          end else if (en) begin
            c_reg[i][j] <= c_nxt[i][j];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_array.sv
// Self-checking bench for systolic_array: random and directed matrices against a matrix-product reference.
// Latency: results compared after 3*DIM-2 en steps, reads sampled 1 time unit after settling.
// Backpressure: none in the DUT; stalls are injected by dropping en.
module tb_systolic_array;

  localparam int DIM     = 8;
  localparam int BITS_AB = 8;
  localparam int BITS_C  = 16;
  localparam int STEPS   = 3*DIM - 2;

  logic                   clk  = 1'b0;
  logic                   rst  = 1'b0;
  logic                   en   = 1'b0;
  logic                   WrEn = 1'b0;
  logic [2:0]             Crow = '0;
  logic [DIM*BITS_AB-1:0] A    = '0;
  logic [DIM*BITS_AB-1:0] B    = '0;
  logic [DIM*BITS_C-1:0]  Cin  = '0;
  logic [DIM*BITS_C-1:0]  Cout;

  int checks = 0;
  int errors = 0;

  // Reference data: operand matrices, per-element preload, and expected result.
  int                amat  [DIM][DIM];
  int                bmat  [DIM][DIM];
  int                bias  [DIM][DIM];
  logic [BITS_C-1:0] exp_c [DIM][DIM];

  systolic_array #(.DIM(DIM), .BITS_AB(BITS_AB), .BITS_C(BITS_C)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .WrEn (WrEn),
    .Crow (Crow),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .Cout (Cout)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Expected C = bias + A*B, wrapped to the accumulator width.
  task automatic compute_ref();
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        int acc;
        acc = bias[r][c];
        for (int m = 0; m < DIM; m++) acc += amat[r][m] * bmat[m][c];
        exp_c[r][c] = BITS_C'(acc);
      end
    end
  endtask

  function automatic logic [DIM*BITS_C-1:0] pack_row(int r);
    logic [DIM*BITS_C-1:0] v;
    v = '0;
    for (int c = 0; c < DIM; c++) v[c*BITS_C +: BITS_C] = exp_c[r][c];
    return v;
  endfunction

  task automatic zero_bias();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) bias[r][c] = 0;
  endtask

  task automatic rand_mats();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        amat[r][c] = int'($urandom_range(255)) - 128;
        bmat[r][c] = int'($urandom_range(255)) - 128;
      end
  endtask

  task automatic identity_mats();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        amat[r][c] = (r == c) ? 1 : 0;
        bmat[r][c] = r*8 + c;
      end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    WrEn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    zero_bias();
  endtask

  // Present step k of the skewed streams: A[i] = amat[i][k-i], B[j] = bmat[k-j][j], zero outside the matrix.
  task automatic drive_step(int k, logic wr_v, int wr_row);
    for (int i = 0; i < DIM; i++) begin
      int m;
      m = k - i;
      if (m >= 0 && m < DIM) A[i*BITS_AB +: BITS_AB] = BITS_AB'(amat[i][m]);
      else                   A[i*BITS_AB +: BITS_AB] = '0;
      if (m >= 0 && m < DIM) B[i*BITS_AB +: BITS_AB] = BITS_AB'(bmat[m][i]);
      else                   B[i*BITS_AB +: BITS_AB] = '0;
    end
    en   = 1'b1;
    WrEn = wr_v;
    Crow = 3'(wr_row);
    @(posedge clk);
    #1;
    en   = 1'b0;
    WrEn = 1'b0;
  endtask

  // Stall cycles with junk on the operand inputs; nothing may be captured.
  task automatic idle_cycles(int n);
    for (int t = 0; t < n; t++) begin
      A = {$urandom, $urandom};
      B = {$urandom, $urandom};
      en = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_row(int r, int v);
    Cin  = {DIM{BITS_C'(v)}};
    Crow = 3'(r);
    WrEn = 1'b1;
    en   = 1'b0;
    @(posedge clk);
    #1;
    WrEn = 1'b0;
    for (int c = 0; c < DIM; c++) bias[r][c] = v;
  endtask

  task automatic run_matmul(logic stall);
    for (int k = 0; k < STEPS; k++) begin
      if (stall && (k == 4 || k == 10 || k == 17)) idle_cycles(3);
      drive_step(k, 1'b0, 0);
    end
  endtask

  task automatic test_reset();
    for (int t = 0; t < 5; t++) begin
      A = {$urandom, $urandom};
      B = {$urandom, $urandom};
      en = 1'b1;
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    for (int r = 0; r < DIM; r++) begin
      A = {$urandom, $urandom};
      B = {$urandom, $urandom};
      WrEn = r[0];
      Cin = {DIM{16'h5a5a}};
      Crow = 3'(r);
      #1;
      checks++;
      if (Cout !== '0)
        $display("FAIL reset_during row %0d: got %h, expected 0", r, Cout);
      @(negedge clk);
    end
    rst  = 1'b0;
    en   = 1'b0;
    WrEn = 1'b0;
    @(posedge clk);
    for (int r = 0; r < DIM; r++) begin
      Crow = 3'(r);
      @(negedge clk);
      checks++;
      if (Cout !== '0) begin
        errors++;
        $display("FAIL reset_after row %0d: got %h, expected 0", r, Cout);
      end
    end
    zero_bias();
  endtask

  task automatic test_identity();
    do_reset();
    for (int r = 0; r < DIM; r++) write_row(r, 0);
    identity_mats();
    compute_ref();
    run_matmul(1'b0);
    for (int r = 0; r < DIM; r++) begin
      Crow = 3'(r);
      #1;
      checks++;
      if (Cout !== pack_row(r)) begin
        errors++;
        $display("FAIL identity row %0d: got %h, expected %h", r, Cout, pack_row(r));
      end
    end
    for (int k = STEPS; k < STEPS + 5; k++) drive_step(k, 1'b0, 0);
    for (int r = 0; r < DIM; r++) begin
      Crow = 3'(r);
      #1;
      checks++;
      if (Cout !== pack_row(r)) begin
        errors++;
        $display("FAIL identity_hold row %0d: got %h, expected %h", r, Cout, pack_row(r));
      end
    end
  endtask

  task automatic test_signed_wrap();
    do_reset();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        amat[r][c] = 127;
        bmat[r][c] = -128;
      end
    compute_ref();
    run_matmul(1'b0);
    for (int r = 0; r < DIM; r++) begin
      Crow = 3'(r);
      #1;
      checks++;
      if (Cout !== {DIM{16'h0400}}) begin
        errors++;
        $display("FAIL signed_wrap row %0d: got %h, expected all 0400", r, Cout);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    identity_mats();
    compute_ref();
    run_matmul(1'b1);
    for (int r = 0; r < DIM; r++) begin
      Crow = 3'(r);
      #1;
      checks++;
      if (Cout !== pack_row(r)) begin
        errors++;
        $display("FAIL stall row %0d: got %h, expected %h", r, Cout, pack_row(r));
      end
    end
  endtask

  task automatic test_collision();
    do_reset();
    rand_mats();
    compute_ref();
    // Row 2 is cleared on step 6, so it keeps only terms that land at step >= 7;
    // term m reaches PE(i,j) at step i+j+m.
    for (int c = 0; c < DIM; c++) begin
      int acc;
      acc = 0;
      for (int m = 0; m < DIM; m++)
        if (2 + c + m >= 7) acc += amat[2][m] * bmat[m][c];
      exp_c[2][c] = BITS_C'(acc);
    end
    for (int k = 0; k < STEPS; k++) begin
      if (k == 6) begin
        Cin = '0;
        drive_step(k, 1'b1, 2);
        Crow = 3'd2;
        #1;
        checks++;
        if (Cout !== '0) begin
          errors++;
          $display("FAIL collision_clear: got %h, expected 0", Cout);
        end
      end else begin
        drive_step(k, 1'b0, 0);
      end
    end
    for (int r = 0; r < DIM; r++) begin
      Crow = 3'(r);
      #1;
      checks++;
      if (Cout !== pack_row(r)) begin
        errors++;
        $display("FAIL collision row %0d: got %h, expected %h", r, Cout, pack_row(r));
      end
    end
  endtask

  task automatic test_preload();
    do_reset();
    for (int r = 0; r < DIM; r++) write_row(r, 100);
    identity_mats();
    compute_ref();
    run_matmul(1'b0);
    for (int r = 0; r < DIM; r++) begin
      Crow = 3'(r);
      #1;
      checks++;
      if (Cout !== pack_row(r)) begin
        errors++;
        $display("FAIL preload row %0d: got %h, expected %h", r, Cout, pack_row(r));
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      do_reset();
      for (int r = 0; r < DIM; r++) write_row(r, int'($urandom_range(65535)) - 32768);
      rand_mats();
      compute_ref();
      for (int k = 0; k < STEPS; k++) begin
        if ($urandom_range(3) == 0) idle_cycles(int'($urandom_range(2)) + 1);
        drive_step(k, 1'b0, 0);
      end
      for (int r = 0; r < DIM; r++) begin
        Crow = 3'(r);
        #1;
        checks++;
        if (Cout !== pack_row(r)) begin
          errors++;
          $display("FAIL random it %0d row %0d: got %h, expected %h", it, r, Cout, pack_row(r));
        end
      end
    end
  endtask

  initial begin
    zero_bias();
    @(negedge clk);
    test_reset();
    test_identity();
    test_signed_wrap();
    test_stall();
    test_collision();
    test_preload();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
